// File: rtl/mdr_pkg.sv
// Shared state encoding and default widths for the memory data register block.
package mdr_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StWrWait = 2'd2
  } mdr_state_e;

  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefAddrW    = 16;
  localparam int unsigned DefWrSelW   = 20;
  localparam int unsigned DefRdSelW   = 19;
  localparam int unsigned DefWrSelBit = 1;
  localparam int unsigned DefRdSelBit = 0;
  localparam int unsigned DefTimeout  = 15;

endpackage

// File: rtl/mem_data_reg_ctrl_if.sv
// Bus, decoder and data-memory signals of the MDR; slave is the MDR side, master the environment.
interface mem_data_reg_ctrl_if
  import mdr_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned WR_SEL_W = DefWrSelW,
  parameter int unsigned RD_SEL_W = DefRdSelW
) ();

  logic [DATA_W-1:0]   a_bus;
  logic [WR_SEL_W-1:0] wr_dec;
  logic [RD_SEL_W-1:0] rd_dec;
  logic [ADDR_W-1:0]   mar_addr;
  logic                mem_rd_cmd;
  logic                mem_wr_cmd;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mdr;
  logic [DATA_W-1:0]   b_bus;
  logic                b_oe;
  logic                busy;
  logic                done;
  logic                err;

  modport slave (
    input  a_bus, wr_dec, rd_dec, mar_addr, mem_rd_cmd, mem_wr_cmd, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mdr, b_bus, b_oe, busy, done, err
  );

  modport master (
    output a_bus, wr_dec, rd_dec, mar_addr, mem_rd_cmd, mem_wr_cmd, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mdr, b_bus, b_oe, busy, done, err
  );

endinterface

// File: rtl/mdr_timeout_cnt.sv
// Wait-cycle counter for memory transactions; expired_o flags the TIMEOUT-th enabled cycle.
module mdr_timeout_cnt #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed wait cycles, so TIMEOUT-1 marks the last one allowed.
  assign expired_o = en_i & (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_data_reg_ctrl.sv
// Memory data register: A-bus load, B-bus drive and a req/ack data-memory sequencer with timeout.
module mem_data_reg_ctrl
  import mdr_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned WR_SEL_W   = DefWrSelW,
  parameter int unsigned RD_SEL_W   = DefRdSelW,
  parameter int unsigned WR_SEL_BIT = DefWrSelBit,
  parameter int unsigned RD_SEL_BIT = DefRdSelBit,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input logic                  clock_i,
  input logic                  reset_i,
  mem_data_reg_ctrl_if.slave   mdr_io
);

  localparam logic [WR_SEL_W-1:0] WrSelHot = WR_SEL_W'(1) << WR_SEL_BIT;
  localparam logic [RD_SEL_W-1:0] RdSelHot = RD_SEL_W'(1) << RD_SEL_BIT;

  mdr_state_e        state_q, state_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ld_sel, oe_sel, cnt_clr, cnt_en, expired;

  // Exact one-hot match only; any other decoder pattern deselects the MDR.
  assign ld_sel = (mdr_io.wr_dec == WrSelHot);
  assign oe_sel = (mdr_io.rd_dec == RdSelHot);

  mdr_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .clear_i   (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        if (ld_sel) begin
          mdr_d = mdr_io.a_bus;
        end
        if (mdr_io.mem_rd_cmd && mdr_io.mem_wr_cmd) begin
          err_d = 1'b1;
        end else if (mdr_io.mem_rd_cmd) begin
          addr_d  = mdr_io.mar_addr;
          state_d = StRdWait;
          err_d   = 1'b0;
        end else if (mdr_io.mem_wr_cmd) begin
          addr_d  = mdr_io.mar_addr;
          state_d = StWrWait;
          err_d   = 1'b0;
        end
      end
      StRdWait, StWrWait: begin
        cnt_en = 1'b1;
        if (ld_sel || mdr_io.mem_rd_cmd || mdr_io.mem_wr_cmd) begin
          err_d = 1'b1;
        end
        // Ack takes priority over a coincident timeout.
        if (mdr_io.mem_ack) begin
          done_d  = 1'b1;
          state_d = StIdle;
          if (state_q == StRdWait) begin
            mdr_d = mdr_io.mem_rdata;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      mdr_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mdr_io.mem_req   = (state_q != StIdle);
  assign mdr_io.mem_we    = (state_q == StWrWait);
  assign mdr_io.busy      = (state_q != StIdle);
  assign mdr_io.mem_addr  = addr_q;
  assign mdr_io.mem_wdata = mdr_q;
  assign mdr_io.mdr       = mdr_q;
  assign mdr_io.done      = done_q;
  assign mdr_io.err       = err_q;
  assign mdr_io.b_oe      = oe_sel & (state_q == StIdle);
  assign mdr_io.b_bus     = mdr_io.b_oe ? mdr_q : '0;

endmodule

// File: tb/tb_mem_data_reg_ctrl.sv
// Directed plus randomized transaction-level checks of mem_data_reg_ctrl against a bench model.
module tb_mem_data_reg_ctrl;

  localparam int TO = 15;
  localparam logic [19:0] SelWr = 20'h2;
  localparam logic [18:0] SelRd = 19'h1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // Reference state: register contents and sticky error as the spec defines them.
  logic [15:0] m_mdr;
  logic        m_err;

  mem_data_reg_ctrl_if bus ();

  mem_data_reg_ctrl dut (
    .clock_i (clk),
    .reset_i (rst),
    .mdr_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_rd_cmd = 1'b0;
    bus.mem_wr_cmd = 1'b0;
    bus.wr_dec     = '0;
    bus.rd_dec     = '0;
    bus.mem_ack    = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_req"}, bus.mem_req, 0);
    chk({tag, "_mdr"}, bus.mdr, m_mdr);
    chk({tag, "_err"}, bus.err, m_err);
  endtask

  task automatic do_load(input logic [19:0] sel, input logic [15:0] data);
    bus.wr_dec = sel;
    bus.a_bus  = data;
    step();
    idle_inputs();
    if (sel == SelWr) m_mdr = data;
    chk("load_mdr", bus.mdr, m_mdr);
    chk("load_err", bus.err, m_err);
  endtask

  task automatic do_oe(input logic [18:0] sel);
    bus.rd_dec = sel;
    #1;
    chk("oe", bus.b_oe, (sel == SelRd));
    chk("b_bus", bus.b_bus, (sel == SelRd) ? m_mdr : 16'h0);
    bus.rd_dec = '0;
  endtask

  // One memory transaction; delay is the wait cycle carrying ack, > TO means no ack at all.
  task automatic xact(input bit is_wr, input logic [15:0] addr, input logic [15:0] rdata,
                      input int delay, input bit with_load, input logic [15:0] ld_data,
                      input bit poke);
    bit acked;
    acked = 1'b0;
    bus.mar_addr = addr;
    if (is_wr) bus.mem_wr_cmd = 1'b1;
    else       bus.mem_rd_cmd = 1'b1;
    if (with_load) begin
      bus.wr_dec = SelWr;
      bus.a_bus  = ld_data;
      m_mdr      = ld_data;
    end
    step();
    idle_inputs();
    bus.mar_addr = 16'($urandom);
    for (int i = 1; i <= TO; i++) begin
      chk("x_req", bus.mem_req, 1);
      chk("x_busy", bus.busy, 1);
      chk("x_we", bus.mem_we, is_wr);
      chk("x_addr", bus.mem_addr, addr);
      chk("x_done_low", bus.done, 0);
      if (is_wr) chk("x_wdata", bus.mem_wdata, m_mdr);
      if (i == 1) begin
        bus.rd_dec = SelRd;
        #1;
        chk("x_oe_busy", bus.b_oe, 0);
        chk("x_bbus_busy", bus.b_bus, 0);
        bus.rd_dec = '0;
        if (poke) begin
          bus.wr_dec = SelWr;
          bus.a_bus  = ~m_mdr;
        end
      end
      if (i == delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end
      step();
      idle_inputs();
      if (i == delay) begin
        acked = 1'b1;
        break;
      end
    end
    if (acked) begin
      if (!is_wr) m_mdr = rdata;
      m_err = poke;
      chk("x_done", bus.done, 1);
    end else begin
      m_err = 1'b1;
      chk("x_done_to", bus.done, 0);
    end
    chk_idle("x_end");
    step();
    chk("x_done_pulse", bus.done, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_mdr    = '0;
    m_err    = 1'b0;
    bus.a_bus     = '0;
    bus.mar_addr  = '0;
    bus.mem_rdata = '0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk_idle("reset");
    chk("reset_we", bus.mem_we, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_addr", bus.mem_addr, 0);

    // Bus load then B-bus drive, and an all-ones write-decoder pattern.
    do_load(SelWr, 16'hBEEF);
    do_oe(SelRd);
    do_oe(19'h3);
    do_load(20'hFFFFF, 16'h1234);

    xact(1'b0, 16'h0040, 16'hA5A5, 3, 1'b0, 16'h0, 1'b0);
    xact(1'b1, 16'h0123, 16'h0, 4, 1'b1, 16'h00FF, 1'b0);
    xact(1'b0, 16'h0200, 16'h5555, TO + 1, 1'b0, 16'h0, 1'b0);
    xact(1'b0, 16'h0300, 16'h7E7E, 1, 1'b0, 16'h0, 1'b0);
    xact(1'b1, 16'h0400, 16'h0, TO, 1'b0, 16'h0, 1'b0);

    // Reset in the middle of a write.
    bus.mar_addr   = 16'h0500;
    bus.mem_wr_cmd = 1'b1;
    step();
    idle_inputs();
    step();
    chk("rst_mid_req_before", bus.mem_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_mdr = '0;
    m_err = 1'b0;
    chk_idle("rst_mid");

    bus.mem_rd_cmd = 1'b1;
    bus.mem_wr_cmd = 1'b1;
    step();
    idle_inputs();
    m_err = 1'b1;
    chk_idle("both_cmds");

    for (int n = 0; n < 40; n++) begin
      int unsigned op;
      op = $urandom_range(0, 5);
      case (op)
        0: do_load(SelWr, 16'($urandom));
        1: begin
          logic [19:0] pat;
          pat = 20'($urandom);
          if (pat == SelWr) pat = 20'h3;
          do_load(pat, 16'($urandom));
        end
        2: do_oe(($urandom_range(0, 1) == 0) ? SelRd : 19'($urandom));
        3: begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 16'($urandom);
          step();
          idle_inputs();
          chk("idle_ack_done", bus.done, 0);
          chk_idle("idle_ack");
        end
        4: begin
          bus.mem_rd_cmd = 1'b1;
          bus.mem_wr_cmd = 1'b1;
          step();
          idle_inputs();
          m_err = 1'b1;
          chk_idle("rnd_both");
        end
        default: xact(1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(1, TO + 3),
                      1'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
